// File: rtl/tran_net_pkg.sv
// Shared types for the transport-to-network packetizer:
// state encodings, default beat width and count-width helper.
package tran_net_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CKSUM   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tran_to_net_packetizer_if.sv
// Transport-side stream and network-side packet bus of the packetizer.
// slave is the packetizer's view, master the driver/consumer view.
interface tran_to_net_packetizer_if
    import tran_net_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              tx_req;
    logic [DATA_W-1:0] dest_addr;
    logic              pkt_ready;
    logic              pkt_rd;
    logic [DATA_W-1:0] pkt_data;
    logic [CNT_W-1:0]  pkt_count;
    logic              pkt_empty;
    logic              abort;
    logic              overrun;
    logic [2:0]        state_dbg;

    modport master (
        output in_data, in_valid, pkt_rd,
        input  tx_req, dest_addr, pkt_ready, pkt_data,
        input  pkt_count, pkt_empty, abort, overrun, state_dbg
    );

    modport slave (
        input  in_data, in_valid, pkt_rd,
        output tx_req, dest_addr, pkt_ready, pkt_data,
        output pkt_count, pkt_empty, abort, overrun, state_dbg
    );

endinterface

// File: rtl/tran_net_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers wrap modulo DEPTH, so
// DEPTH need not be a power of two.
module tran_net_sync_fifo
    import tran_net_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 1024,
    localparam int CW     = cnt_w(DEPTH),
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              wr_ok;
    logic              rd_ok;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (srst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= inc(wp);
            if (rd_ok) rp <= inc(rp);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end

endmodule

// File: rtl/tran_to_net_packetizer.sv
// Transport-to-network packetizer: header capture, payload FIFO, gap abort.
// Define TRAN_TO_NET_CHECKSUM_EN to append an XOR checksum word.
module tran_to_net_packetizer
    import tran_net_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = 16,
    parameter int DEPTH   = 1024,
    parameter int GAP_MAX = 0
)(
    input logic                clk,
    input logic                reset,
    tran_to_net_packetizer_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam int GW = $clog2(GAP_MAX + 2);

`ifdef TRAN_TO_NET_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CKSUM;
    logic [DATA_W-1:0] csum_q;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] dest_q;
    logic [DATA_W-1:0] wr_data;
    logic [BW-1:0]     beat_q;
    logic [GW-1:0]     gap_q;
    logic              overrun_q;
    logic              abort_q;
    logic              wr_en;
    logic              rd_en;
    logic              abort_evt;
    logic              ovr_evt;
    logic              tx_req;
    logic              pkt_ready;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_cnt;
    logic [DATA_W-1:0] fifo_dout;
    logic              last_beat;
    logic              gap_hit;

    assign last_beat = (beat_q == BW'(PKT_LEN - 1));
    // an idle cycle now would push the gap count past GAP_MAX
    assign gap_hit   = (int'(gap_q) >= GAP_MAX);
    assign rd_en     = bus.pkt_rd & pkt_ready & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (fifo_empty) state_nxt = ST_ARMED;
            ST_ARMED:
                if (bus.in_valid) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD:
                if (bus.in_valid) begin
                    if (last_beat) state_nxt = ST_TAIL;
                end else if (gap_hit) begin
                    state_nxt = ST_IDLE;
                end
            ST_CKSUM:
                state_nxt = ST_DONE;
            ST_DONE:
                if (fifo_empty) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_req    = 1'b0;
        pkt_ready = 1'b0;
        wr_en     = 1'b0;
        wr_data   = bus.in_data;
        abort_evt = 1'b0;
        ovr_evt   = 1'b0;
        case (state)
            ST_IDLE:
                ovr_evt = bus.in_valid;
            ST_ARMED:
                tx_req = 1'b1;
            ST_PAYLOAD: begin
                tx_req    = 1'b1;
                wr_en     = bus.in_valid;
                ovr_evt   = bus.in_valid & fifo_full;
                abort_evt = ~bus.in_valid & gap_hit;
            end
`ifdef TRAN_TO_NET_CHECKSUM_EN
            ST_CKSUM: begin
                wr_en   = 1'b1;
                wr_data = csum_q;
                ovr_evt = bus.in_valid | fifo_full;
            end
`endif
            ST_DONE: begin
                pkt_ready = 1'b1;
                ovr_evt   = bus.in_valid;
            end
            default: ovr_evt = bus.in_valid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q    <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= abort_evt;
            if (ovr_evt) overrun_q <= 1'b1;
            if (state == ST_ARMED && bus.in_valid) begin
                dest_q <= bus.in_data;
                beat_q <= '0;
                gap_q  <= '0;
            end
            if (state == ST_PAYLOAD) begin
                if (bus.in_valid) begin
                    beat_q <= beat_q + 1'b1;
                    gap_q  <= '0;
                end else if (!gap_hit) begin
                    gap_q <= gap_q + 1'b1;
                end
            end
        end
    end

`ifdef TRAN_TO_NET_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state == ST_ARMED && bus.in_valid) begin
            csum_q <= '0;
        end else if (state == ST_PAYLOAD && bus.in_valid) begin
            csum_q <= csum_q ^ bus.in_data;
        end
    end
`endif

    tran_net_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset | abort_evt),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.tx_req    = tx_req;
    assign bus.dest_addr = dest_q;
    assign bus.pkt_ready = pkt_ready;
    assign bus.pkt_data  = fifo_dout;
    assign bus.pkt_count = fifo_cnt;
    assign bus.pkt_empty = fifo_empty;
    assign bus.abort     = abort_q;
    assign bus.overrun   = overrun_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_tran_to_net_packetizer.sv
// Scoreboard bench: dut_a (GAP_MAX=0, DEPTH=32), dut_b (GAP_MAX=2, DEPTH=17).
// Works with or without TRAN_TO_NET_CHECKSUM_EN defined.
module tb_tran_to_net_packetizer;

`ifdef TRAN_TO_NET_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int PL = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    bit         tgt = 1'b0;
    logic       drv_valid = 1'b0;
    logic       drv_rd = 1'b0;
    logic [7:0] drv_data = 8'h00;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    tran_to_net_packetizer_if #(.DATA_W(8), .DEPTH(32)) ia ();
    tran_to_net_packetizer_if #(.DATA_W(8), .DEPTH(17)) ib ();

    tran_to_net_packetizer #(
        .DATA_W(8), .PKT_LEN(PL), .DEPTH(32), .GAP_MAX(0)
    ) dut_a (.clk(clk), .reset(reset), .bus(ia));

    tran_to_net_packetizer #(
        .DATA_W(8), .PKT_LEN(PL), .DEPTH(17), .GAP_MAX(2)
    ) dut_b (.clk(clk), .reset(reset), .bus(ib));

    assign ia.in_data  = drv_data;
    assign ib.in_data  = drv_data;
    assign ia.in_valid = drv_valid & ~tgt;
    assign ib.in_valid = drv_valid & tgt;
    assign ia.pkt_rd   = drv_rd & ~tgt;
    assign ib.pkt_rd   = drv_rd & tgt;

    logic       s_tx, s_rdy, s_abort, s_ovr, s_empty;
    logic [2:0] s_st;
    logic [7:0] s_dest;
    int         s_cnt;
    assign s_tx    = tgt ? ib.tx_req    : ia.tx_req;
    assign s_rdy   = tgt ? ib.pkt_ready : ia.pkt_ready;
    assign s_abort = tgt ? ib.abort     : ia.abort;
    assign s_ovr   = tgt ? ib.overrun   : ia.overrun;
    assign s_empty = tgt ? ib.pkt_empty : ia.pkt_empty;
    assign s_st    = tgt ? ib.state_dbg : ia.state_dbg;
    assign s_dest  = tgt ? ib.dest_addr : ia.dest_addr;
    assign s_cnt   = tgt ? int'(ib.pkt_count) : int'(ia.pkt_count);

    // monitors: pop and compare on every honoured read
    always @(negedge clk) begin
        if (ia.pkt_rd && ia.pkt_ready && !ia.pkt_empty) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a: got %h with no expected word", ia.pkt_data);
            end else begin
                automatic logic [7:0] e = qa.pop_front();
                if (ia.pkt_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_a: got %h expected %h", ia.pkt_data, e);
                end
            end
        end
        if (ib.pkt_rd && ib.pkt_ready && !ib.pkt_empty) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b: got %h with no expected word", ib.pkt_data);
            end else begin
                automatic logic [7:0] e = qb.pop_front();
                if (ib.pkt_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_b: got %h expected %h", ib.pkt_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        if (tgt) qb.push_back(d);
        else     qa.push_back(d);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (s_tx !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("tx_req_wait", s_tx, 1);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base,
                            input int gap_at, input int gap_len);
        logic [7:0] x = 8'h00;
        wait_tx();
        drv_data  = hdr;
        drv_valid = 1'b1;
        tick();
        for (int i = 0; i < PL; i++) begin
            if (i == gap_at) begin
                drv_valid = 1'b0;
                repeat (gap_len) tick();
                drv_valid = 1'b1;
            end
            drv_data = base + 8'(i);
            x ^= drv_data;
            push(drv_data);
            tick();
        end
        drv_valid = 1'b0;
        if (CK != 0) push(x);
    endtask

    task automatic send_raw(input logic [7:0] hdr, input int n);
        wait_tx();
        drv_data  = hdr;
        drv_valid = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            drv_data = 8'hC0 + 8'(i);
            tick();
        end
        drv_valid = 1'b0;
    endtask

    task automatic read_all(input int n);
        drv_rd = 1'b1;
        repeat (n) tick();
        drv_rd = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_tx_req", s_tx, 0);
        chk("rst_pkt_ready", s_rdy, 0);
        chk("rst_abort", s_abort, 0);
        chk("rst_overrun", s_ovr, 0);
        chk("rst_dest", s_dest, 0);
        chk("rst_state", s_st, 0);
        chk("rst_count", s_cnt, 0);
        chk("rst_empty", s_empty, 1);
        reset = 1'b0;

        // nominal packet
        send_pkt(8'h5A, 8'h01, -1, 0);
        chk("tx_drop", s_tx, 0);
        chk("ready_latency", s_rdy, CK == 0);
        repeat (CK) tick();
        chk("nom_ready", s_rdy, 1);
        chk("nom_count", s_cnt, PL + CK);
        chk("nom_dest", s_dest, 8'h5A);
        chk("nom_state", s_st, 4);
        read_all(PL + CK);
        chk("nom_drain", qa.size(), 0);
        chk("nom_empty", s_empty, 1);
        chk("nom_hold_done", s_st, 4);
        tick();
        chk("nom_idle", s_st, 0);
        chk("nom_ready_low", s_rdy, 0);
        tick();
        chk("nom_armed", s_st, 1);

        // reads ignored while filling; overrun in DONE
        drv_rd = 1'b1;
        send_pkt(8'h66, 8'h80, -1, 0);
        drv_rd = 1'b0;
        repeat (CK) tick();
        chk("rd_gated", s_cnt, PL + CK);
        drv_data  = 8'hEE;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        chk("ovr_set", s_ovr, 1);
        chk("ovr_no_write", s_cnt, PL + CK);
        read_all(PL + CK);
        chk("gate_drain", qa.size(), 0);
        tick();
        tick();
        chk("gate_armed", s_st, 1);
        chk("ovr_sticky", s_ovr, 1);

        // truncation with GAP_MAX=0
        send_raw(8'h22, 5);
        chk("trunc_count", s_cnt, 5);
        tick();
        chk("trunc_abort", s_abort, 1);
        chk("trunc_empty", s_empty, 1);
        chk("trunc_count0", s_cnt, 0);
        chk("trunc_idle", s_st, 0);
        chk("trunc_dest", s_dest, 8'h22);
        tick();
        chk("abort_pulse", s_abort, 0);
        chk("trunc_rearm", s_st, 1);

        // reset mid-packet
        send_raw(8'h77, 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_count", s_cnt, 0);
        chk("mid_rst_tx", s_tx, 0);
        chk("mid_rst_state", s_st, 0);
        chk("mid_rst_abort", s_abort, 0);
        chk("mid_rst_ovr", s_ovr, 0);

        // GAP_MAX=2: 2-cycle gap tolerated
        tgt = 1'b1;
        send_pkt(8'h33, 8'h40, 8, 2);
        chk("gap_ready_lat", s_rdy, CK == 0);
        repeat (CK) tick();
        chk("gap_ready", s_rdy, 1);
        chk("gap_count", s_cnt, PL + CK);
        chk("gap_dest", s_dest, 8'h33);
        read_all(PL + CK);
        chk("gap_drain", qb.size(), 0);

        // GAP_MAX=2: 3-cycle gap aborts
        send_raw(8'h44, 4);
        tick();
        tick();
        chk("gap2_payload", s_st, 2);
        chk("gap2_no_abort", s_abort, 0);
        tick();
        chk("gap3_abort", s_abort, 1);
        chk("gap3_idle", s_st, 0);
        chk("gap3_empty", s_empty, 1);
        chk("gap3_dest", s_dest, 8'h44);

        tick();
        chk("final_qa", qa.size(), 0);
        chk("final_qb", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
